// File: rtl/bits_skid_pkg.sv
// Shared constants for the bits skid buffer: state encoding and parameter defaults.
package bits_skid_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

  localparam int DEFAULT_WIDTH       = 1;
  localparam int DEFAULT_RESET_VALUE = 0;

endpackage

// File: rtl/bits_reg_en.sv
// WIDTH-bit load-enable register with synchronous active-low reset to RESET_VALUE.
module bits_reg_en
  import bits_skid_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      q <= RESET_VALUE;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/bits_skid_buffer.sv
// Two-entry registered valid/ready skid buffer; O, O_valid and I_ready all come from flops.
//
// state    | meaning
// ST_EMPTY | no word held; O shows the last popped word (or RESET_VALUE)
// ST_ONE   | main holds the word on O
// ST_FULL  | main on O, skid holds the next word; upstream stalled
module bits_skid_buffer
  import bits_skid_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic [WIDTH-1:0] I,
  input  logic             I_valid,
  output logic             I_ready,
  output logic [WIDTH-1:0] O,
  output logic             O_valid,
  input  logic             O_ready,
  output logic [1:0]       COUNT
);

  skid_state_t      state;
  skid_state_t      state_next;
  logic             in_fire;
  logic             out_fire;
  logic             load_main;
  logic             load_skid;
  logic             main_from_skid;
  logic [WIDTH-1:0] main_d;
  logic [WIDTH-1:0] skid_q;

  assign in_fire  = I_valid & I_ready;
  assign out_fire = O_valid & O_ready;

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (in_fire) begin
          state_next = ST_ONE;
          load_main  = 1'b1;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          state_next = ST_FULL;
          load_skid  = 1'b1;
        end else if (out_fire) begin
          state_next = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // I_ready is low here, so only a pop can happen
        if (out_fire) begin
          state_next     = ST_ONE;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_next = ST_EMPTY;
    endcase
  end

  always_comb begin
    O_valid = (state != ST_EMPTY);
    I_ready = RESETN & (state != ST_FULL);
    case (state)
      ST_ONE:  COUNT = 2'd1;
      ST_FULL: COUNT = 2'd2;
      default: COUNT = 2'd0;
    endcase
  end

  assign main_d = main_from_skid ? skid_q : I;

  bits_reg_en #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_main (
    .clk    (CLK),
    .resetn (RESETN),
    .en     (load_main),
    .d      (main_d),
    .q      (O)
  );

  bits_reg_en #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_skid (
    .clk    (CLK),
    .resetn (RESETN),
    .en     (load_skid),
    .d      (I),
    .q      (skid_q)
  );

endmodule

// File: doc/bits_skid_buffer.md
Name: bits_skid_buffer

Overview:
- Registered two-entry valid/ready skid buffer that consumes the WIDTH-bit output of a Buf instance and forwards it to a downstream consumer.
- Breaks the combinational path on both data and backpressure: O, O_valid and I_ready all come from flops.
- Sits directly downstream of the Buf in generated top-level designs; it is the first clocked stage after the constant/Buf chain.

Parameters:
- WIDTH, 1, data width in bits of I and O.
- RESET_VALUE, 0, value driven on O after reset until the first word is accepted.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RESETN  input  1  synchronous, active-low reset.
- I  input  WIDTH  upstream data, typically the Buf O.
- I_valid  input  1  upstream word is valid this cycle.
- I_ready  output  1  buffer can accept a word this cycle.
- O  output  WIDTH  downstream data.
- O_valid  output  1  O holds a valid word.
- O_ready  input  1  downstream accepts O this cycle.
- COUNT  output  2  occupancy, range 0..2.

Behaviour:
- Reset
  - One clock is synchronous and the reset is synchronous, active-low: RESETN low at a rising CLK edge forces state EMPTY, main/skid data to RESET_VALUE, O_valid=0, COUNT=0.
  - While RESETN is low, I_ready is gated to 0 combinationally and I_valid/O_ready are ignored.
  - Reset mid-operation discards any buffered words. There is no flush handshake.
- Handshake
  - in_fire = I_valid & I_ready.
  - out_fire = O_valid & O_ready.
  - A transfer occurs only on the clock edge where fire is 1.
- Storage
  - main register drives O.
  - skid register holds the overflow word.
- State machine (2-bit state: EMPTY, ONE, FULL)
  - EMPTY:
    - in_fire -> ONE, main<=I.
    - otherwise stay in EMPTY.
  - ONE:
    - in_fire & out_fire -> ONE, main<=I.
    - in_fire only -> FULL, skid<=I.
    - out_fire only -> EMPTY.
    - neither -> ONE.
  - FULL:
    - out_fire -> ONE, main<=skid.
    - otherwise hold. in_fire is impossible because I_ready=0.
- Output decode
  - O_valid = (state != EMPTY).
  - I_ready = RESETN & (state != FULL).
  - COUNT = 0/1/2 for EMPTY/ONE/FULL.
  - No combinational path from O_ready to I_ready, or from I to O.
- Latency and throughput
  - Latency: a word accepted at edge n appears on O with O_valid=1 after edge n; one cycle.
  - Sustained throughput is 1 word/cycle when O_ready is held high.
- Stability
  - While O_valid=1 and O_ready=0, O must not change.
  - In EMPTY, O keeps the last word popped. After reset, O is RESET_VALUE.
- Ordering: strict FIFO. The skid word is never emitted before the main word.
- I_valid asserted while I_ready=0 has no effect. Upstream is not required to hold data, but the Buf source does.

Decomposition:
- Shared package bits_skid_pkg holds:
  - state encoding constants ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2.
  - default WIDTH.
  - default RESET_VALUE.
- One sub-module, bits_reg_en:
  - WIDTH-bit register with synchronous active-low reset to RESET_VALUE and a load enable.
  - Instanced twice, for main and skid.
- The FSM and output decode stay in the top module.

Test Plan:
- Reset: hold RESETN=0 for 2 edges with I_valid=1, I=1 -> O=0, O_valid=0, I_ready=0, COUNT=0. Release -> I_ready=1 next cycle.
- Streaming, WIDTH=8: O_ready=1, feed 0x01,0x02,0x03 on consecutive cycles -> O shows 0x01,0x02,0x03 one cycle later each, COUNT stays 1, no bubbles.
- Backpressure fill: O_ready=0, push 0xAA then 0xBB -> COUNT=2, I_ready=0, O=0xAA held stable. Third push 0xCC is ignored.
- Drain order: from FULL {0xAA,0xBB}, O_ready=1 for 2 cycles with I_valid=0 -> O=0xAA then 0xBB, then O_valid=0, COUNT=0, O stays 0xBB.
- Simultaneous push/pop in ONE: main=0x10, I=0x20 with I_valid=1 and O_ready=1 -> next cycle O=0x20, COUNT=1, skid unused.
- Reset mid-operation: in FULL, drop RESETN for 1 edge -> COUNT=0, O_valid=0, O=RESET_VALUE. Buffered 0xAA/0xBB never appear.
